// File: rtl/fetch_ctrl.sv
// Program-counter / instruction-fetch controller: IDLE/RUN/DONE run handshake,
// sequential pc with branch targets taken from a small writable lookup table.

module fetch_lut_entry #(
    parameter int PW = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [PW-1:0] i_wdata,
    output logic [PW-1:0] o_q
);
    logic [PW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)   r_q <= '0;
        else if (i_we) r_q <= i_wdata;
    end

    assign o_q = r_q;
endmodule

module fetch_ctrl #(
    parameter int PW = 10,
    parameter int A  = 3,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req,
    input  logic          i_halt,
    input  logic          i_branch_taken,
    input  logic [A-1:0]  i_target_sel,
    input  logic          i_lut_we,
    input  logic [A-1:0]  i_lut_waddr,
    input  logic [PW-1:0] i_lut_wdata,
    output logic [PW-1:0] o_pc,
    output logic          o_running,
    output logic          o_done,
    output logic [CW-1:0] o_cycle_cnt
);
    localparam int NE = 2**A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic          we;
        logic [A-1:0]  addr;
        logic [PW-1:0] data;
    } lut_wr_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_pc, w_pc_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [CW-1:0]       w_cnt_inc;
    logic [PW-1:0]       w_target;
    lut_wr_t             w_wr;
    logic [NE-1:0][PW-1:0] w_lut;

    assign w_wr = '{we: i_lut_we, addr: i_lut_waddr, data: i_lut_wdata};

    // Entries are plain registers, so a same-cycle write is only seen by the
    // branch read after the edge.
    for (genvar g = 0; g < NE; g++) begin : g_lut
        fetch_lut_entry #(.PW(PW)) u_entry (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_we    (w_wr.we && (w_wr.addr == A'(g))),
            .i_wdata (w_wr.data),
            .o_q     (w_lut[g])
        );
    end

    assign w_target  = w_lut[i_target_sel];
    assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt = '0;
                if (i_req) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                // halt wins over a simultaneous taken branch; pc stays on HALT
                if (i_halt) begin
                    w_state_nxt = S_DONE;
                end else if (i_branch_taken) begin
                    w_pc_nxt  = w_target;
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_pc_nxt  = r_pc + PW'(1);
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DONE: begin
                if (i_req) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_pc        = r_pc;
    assign o_running   = (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);
    assign o_cycle_cnt = r_cnt;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, each cycle
// compared against a behavioural program-execution model.

module tb_fetch_ctrl;
    localparam int PW = 10;
    localparam int A  = 3;
    localparam int CW = 6;
    localparam int PCMOD = 1 << PW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_reset, i_req, i_halt, i_branch_taken, i_lut_we;
    logic [A-1:0]  i_target_sel, i_lut_waddr;
    logic [PW-1:0] i_lut_wdata;
    logic [PW-1:0] o_pc;
    logic          o_running, o_done;
    logic [CW-1:0] o_cycle_cnt;

    fetch_ctrl #(.PW(PW), .A(A), .CW(CW)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req          (i_req),
        .i_halt         (i_halt),
        .i_branch_taken (i_branch_taken),
        .i_target_sel   (i_target_sel),
        .i_lut_we       (i_lut_we),
        .i_lut_waddr    (i_lut_waddr),
        .i_lut_wdata    (i_lut_wdata),
        .o_pc           (o_pc),
        .o_running      (o_running),
        .o_done         (o_done),
        .o_cycle_cnt    (o_cycle_cnt)
    );

    always #5 i_clk = ~i_clk;

    // model: is a program executing, has it finished, where is it, how long
    bit m_run, m_done;
    int m_pc, m_cnt;
    int m_lut[1<<A];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, req, halt, br, input int sel,
                              input bit we, input int waddr, input int wdata);
        if (rst) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
            foreach (m_lut[k]) m_lut[k] = 0;
            return;
        end
        if (!m_run) begin
            if (req) begin m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; end
        end else if (halt) begin
            m_run = 0; m_done = 1;
        end else begin
            m_pc  = br ? m_lut[sel] : (m_pc + 1) % PCMOD;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
        if (we) m_lut[waddr] = wdata;
    endtask

    task automatic cyc(input bit rst = 0, input bit req = 0, input bit halt = 0,
                       input bit br = 0, input int sel = 0, input bit we = 0,
                       input int waddr = 0, input int wdata = 0);
        i_reset = rst; i_req = req; i_halt = halt; i_branch_taken = br;
        i_target_sel = A'(sel); i_lut_we = we; i_lut_waddr = A'(waddr);
        i_lut_wdata = PW'(wdata);
        model_step(rst, req, halt, br, sel, we, waddr, wdata);
        @(posedge i_clk);
        #1;
        chk("pc", 32'(o_pc), 32'(m_pc));
        chk("running", 32'(o_running), 32'(m_run));
        chk("done", 32'(o_done), 32'(m_done));
        chk("cycle_cnt", 32'(o_cycle_cnt), 32'(m_cnt));
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_pc != target && m_run && guard < 2000) begin
            cyc();
            guard++;
        end
        chk("run_to_pc", 32'(o_pc), 32'(target));
    endtask

    initial begin
        // 1: reset, start, halt at pc 5
        cyc(.rst(1)); cyc(.rst(1));
        chk("reset_pc", 32'(o_pc), 32'd0);
        chk("reset_cnt", 32'(o_cycle_cnt), 32'd0);
        cyc(.req(1));
        chk("start_pc", 32'(o_pc), 32'd0);
        chk("start_running", 32'(o_running), 32'd1);
        run_to(5);
        cyc(.halt(1));
        chk("halt_done", 32'(o_done), 32'd1);
        chk("halt_pc", 32'(o_pc), 32'd5);
        chk("halt_cnt", 32'(o_cycle_cnt), 32'd5);
        cyc(); cyc(.halt(1), .br(1));   // ignored outside RUN

        // 2: LUT[3]=0x040 written, branch at pc 2
        cyc(.rst(1));
        cyc(.we(1), .waddr(3), .wdata('h040));
        cyc(.req(1));
        run_to(2);
        cyc(.br(1), .sel(3));
        chk("branch_pc", 32'(o_pc), 32'h040);
        cyc();
        chk("branch_next", 32'(o_pc), 32'h041);
        cyc(.halt(1));

        // 3: halt and branch together at pc 4
        cyc(.req(1));
        run_to(4);
        cyc(.halt(1), .br(1), .sel(3));
        chk("halt_over_branch_pc", 32'(o_pc), 32'd4);
        chk("halt_over_branch_done", 32'(o_done), 32'd1);

        // 4: same-cycle write and branch read of index 1
        cyc(.we(1), .waddr(1), .wdata('h010));
        cyc(.req(1));
        cyc(.br(1), .sel(1), .we(1), .waddr(1), .wdata('h100));
        chk("old_entry_pc", 32'(o_pc), 32'h010);
        cyc(.br(1), .sel(1));
        chk("new_entry_pc", 32'(o_pc), 32'h100);

        // 5: wrap from 0x3FF
        cyc(.we(1), .waddr(2), .wdata('h3FF));
        cyc(.br(1), .sel(2));
        chk("pc_top", 32'(o_pc), 32'h3FF);
        cyc();
        chk("pc_wrap", 32'(o_pc), 32'h000);
        chk("wrap_running", 32'(o_running), 32'd1);

        // 6: reset at pc 7 clears everything including the LUT
        run_to(7);
        cyc(.rst(1), .req(1), .br(1), .sel(2));
        chk("abort_pc", 32'(o_pc), 32'd0);
        chk("abort_running", 32'(o_running), 32'd0);
        cyc(.req(1));
        cyc(.br(1), .sel(2));
        chk("lut_cleared", 32'(o_pc), 32'd0);
        cyc(.halt(1));
        cyc(.req(1));
        chk("restart_done", 32'(o_done), 32'd0);
        chk("restart_pc", 32'(o_pc), 32'd0);

        // counter saturation; req while running is ignored
        for (int i = 0; i < CMAX + 8; i++) cyc(.req(i % 5 == 0));
        chk("cnt_sat", 32'(o_cycle_cnt), 32'(CMAX));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(.rst($urandom_range(0, 63) == 0),
                .req($urandom_range(0, 3) == 0),
                .halt($urandom_range(0, 15) == 0),
                .br($urandom_range(0, 3) == 0),
                .sel(int'($urandom_range(0, (1 << A) - 1))),
                .we($urandom_range(0, 3) == 0),
                .waddr(int'($urandom_range(0, (1 << A) - 1))),
                .wdata(int'($urandom_range(0, PCMOD - 1))));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
